aes_decipher_iter: RTL and testbench
====================================

AES_DECIPHER_ITER -- requirements
Module: aes_decipher_iter

Interface
REQ-001 Parameter KEY256_EN, default 1: 1 enables AES-256 mode; 0 builds AES-128 only.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 abort  input  1  synchronous cancel of the block in flight.
REQ-005 in_valid  input  1  ciphertext block offered.
REQ-006 in_ready  output  1  block accepted on an edge where in_valid and in_ready are both high.
REQ-007 in_keylen  input  1  0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14); sampled at accept.
REQ-008 in_block  input  128  ciphertext, byte 0 in bits [127:120].
REQ-009 round  output  4  round-key index requested this cycle.
REQ-010 round_key  input  128  key for index round, valid combinationally in the same cycle.
REQ-011 out_valid  output  1  plaintext held in out_block.
REQ-012 out_ready  input  1  consumer accepts out_block when out_valid is high.
REQ-013 out_block  output  128  plaintext, same byte order as in_block.

Function
REQ-014 The FSM SHALL have the states IDLE, INIT, MAIN and FINAL; in_ready SHALL be high only in IDLE.
REQ-015 IDLE, on accept: latch in_block and Nr; round <= Nr; go to INIT.
REQ-016 INIT: state <= in_block XOR round_key; round <= Nr-1; go to MAIN.
REQ-017 MAIN, for round r from Nr-1 down to 1, one per cycle: InvShiftRows, InvSubBytes, AddRoundKey(round_key), InvMixColumns; round <= r-1; at r=1 go to FINAL.
REQ-018 FINAL, with round=0: InvShiftRows, InvSubBytes, AddRoundKey; if out_valid=0 or out_ready=1, load out_block, set out_valid and go to IDLE; otherwise stall in FINAL with state and round unchanged.
REQ-019 Latency: out_valid SHALL rise Nr+1 edges after the accept edge when unstalled (11 for AES-128, 15 for AES-256).
REQ-020 Minimum issue period: Nr+2 cycles per block.
REQ-021 out_valid SHALL clear on an edge with out_ready=1 unless FINAL loads a new block on the same edge, in which case out_valid stays high with the new data.
REQ-022 While out_valid=1 and out_ready=0, out_block SHALL remain stable.
REQ-023 With KEY256_EN=0, in_keylen SHALL be ignored and Nr=10.
REQ-024 abort=1 SHALL force IDLE and round=0 on the next edge, discarding the internal state; the output register and out_valid SHALL be unaffected.
REQ-025 abort in IDLE SHALL take priority over a simultaneous accept, so no block is accepted.
REQ-026 round SHALL be 0 in IDLE.

Reset
REQ-027 On reset_n low, asynchronously: FSM=IDLE, round=0, internal state=0, out_block=0, out_valid=0; in_ready therefore reads 1.
REQ-028 Reset mid-block SHALL discard that block with no output produced.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the AES128_ROUNDS=10 and AES256_ROUNDS=14 constants, and the GF(2^8) multiply functions gm2/gm09/gm11/gm13/gm14.
REQ-030 One sub-module aes_inv_mixcolumn (32-bit column in, 32-bit out, purely combinational) SHALL be instantiated four times.
REQ-031 The sixteen InvSubBytes lookups SHALL reuse the existing aes_inv_sbox module.

Verification
REQ-032 AES-128 FIPS-197 C.1: key 000102..0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> out_block 00112233445566778899aabbccddeeff, out_valid 11 cycles after accept.
REQ-033 AES-256 FIPS-197 C.3: key 000102..1f, ciphertext 8ea2b7ca516745bfeafc49904b496089 -> out_block 00112233445566778899aabbccddeeff after 15 cycles; round sequence 14,13,..,0.
REQ-034 Backpressure: hold out_ready=0, issue a second block -> FSM stalls in FINAL, first result stable; raising out_ready -> second result appears on the following edge.
REQ-035 Back-to-back blocks with in_valid held high -> accepts spaced exactly Nr+2 cycles apart, results correct and in order.
REQ-036 Abort at MAIN round 5 -> IDLE next cycle with in_ready=1; the next block decrypts correctly. reset_n pulse mid-block -> all outputs 0, and out_valid never rises for that block.
REQ-037 KEY256_EN=0 build, in_keylen=1 -> treated as AES-128, with C.1 vectors passing in 11 cycles.

Source files
------------

// File: rtl/aes_decipher_iter_pkg.sv
// Shared types, round counts and GF(2^8) multipliers for the iterative AES decipher.
package aes_decipher_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_MAIN  = 2'd2,
    ST_FINAL = 2'd3
  } fsm_state_t;

  localparam int unsigned AES128_ROUNDS = 10;
  localparam int unsigned AES256_ROUNDS = 14;

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm09(input logic [7:0] b);
    return gm2(gm2(gm2(b))) ^ b;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] b);
    return gm2(gm2(gm2(b))) ^ gm2(b) ^ b;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] b);
    return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ b;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] b);
    return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ gm2(b);
  endfunction

endpackage

// File: rtl/aes_decipher_iter_mixcolumn.sv
// InvMixColumns on one 32-bit column, top byte is row 0.
module aes_inv_mixcolumn
  import aes_decipher_iter_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_a0, w_a1, w_a2, w_a3;

  assign {w_a0, w_a1, w_a2, w_a3} = i_col;

  assign o_col[31:24] = gm14(w_a0) ^ gm11(w_a1) ^ gm13(w_a2) ^ gm09(w_a3);
  assign o_col[23:16] = gm09(w_a0) ^ gm14(w_a1) ^ gm11(w_a2) ^ gm13(w_a3);
  assign o_col[15:8]  = gm13(w_a0) ^ gm09(w_a1) ^ gm14(w_a2) ^ gm11(w_a3);
  assign o_col[7:0]   = gm11(w_a0) ^ gm13(w_a1) ^ gm09(w_a2) ^ gm14(w_a3);

endmodule

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box: inverse affine transform followed by GF(2^8) inversion (a^254).
module aes_inv_sbox
  import aes_decipher_iter_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gm2(x);
    end
    return p;
  endfunction

  // Square-and-multiply over exponent 254 = 8'b1111_1110; zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, a);
    end
    return r;
  endfunction

  logic [7:0] w_aff;

  assign w_aff  = {i_byte[6:0], i_byte[7]} ^ {i_byte[4:0], i_byte[7:5]}
                ^ {i_byte[1:0], i_byte[7:2]} ^ 8'h05;
  assign o_byte = gf_inv(w_aff);

endmodule

// File: rtl/aes_decipher_iter.sv
// Iterative AES-128/256 decipher, one round per clock, round keys fetched by index.
module aes_decipher_iter
  import aes_decipher_iter_pkg::*;
#(
  parameter int KEY256_EN = 1
)
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         abort,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_keylen,
  input  logic [127:0] in_block,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block
);

  fsm_state_t   r_fsm, w_fsm_next;
  logic [3:0]   r_round, w_round_next, w_nr;
  logic [127:0] r_state, w_state_next;
  logic [127:0] r_out_block, w_out_block_next;
  logic         r_out_valid, w_out_valid_next;
  logic [127:0] w_isr, w_isb, w_ark, w_imc;

  assign w_nr = (KEY256_EN != 0 && in_keylen) ? 4'(AES256_ROUNDS) : 4'(AES128_ROUNDS);

  // Byte i sits at bits [127-8i -: 8]; column c = i/4, row r = i%4.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
      localparam int COL = gi / 4;
      localparam int ROW = gi % 4;
      localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
      assign w_isr[127-8*gi -: 8] = r_state[127-8*SRC -: 8];
      aes_inv_sbox u_sbox (
        .i_byte (w_isr[127-8*gi -: 8]),
        .o_byte (w_isb[127-8*gi -: 8])
      );
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_cols
      aes_inv_mixcolumn u_imc (
        .i_col (w_ark[127-32*gi -: 32]),
        .o_col (w_imc[127-32*gi -: 32])
      );
    end
  endgenerate

  assign w_ark = w_isb ^ round_key;

  always_comb begin
    w_fsm_next       = r_fsm;
    w_round_next     = r_round;
    w_state_next     = r_state;
    w_out_block_next = r_out_block;
    w_out_valid_next = r_out_valid & ~out_ready;
    if (abort) begin
      w_fsm_next   = ST_IDLE;
      w_round_next = 4'd0;
      w_state_next = '0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          w_round_next = 4'd0;
          if (in_valid) begin
            w_state_next = in_block;
            w_round_next = w_nr;
            w_fsm_next   = ST_INIT;
          end
        end
        ST_INIT: begin
          w_state_next = r_state ^ round_key;
          w_round_next = r_round - 4'd1;
          w_fsm_next   = ST_MAIN;
        end
        ST_MAIN: begin
          w_state_next = w_imc;
          w_round_next = r_round - 4'd1;
          if (r_round == 4'd1) w_fsm_next = ST_FINAL;
        end
        ST_FINAL: begin
          // Hold here while the previous result is still unconsumed.
          if (!r_out_valid || out_ready) begin
            w_out_block_next = w_ark;
            w_out_valid_next = 1'b1;
            w_fsm_next       = ST_IDLE;
          end
        end
        default: w_fsm_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm       <= ST_IDLE;
      r_round     <= 4'd0;
      r_state     <= '0;
      r_out_block <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_next;
      r_round     <= w_round_next;
      r_state     <= w_state_next;
      r_out_block <= w_out_block_next;
      r_out_valid <= w_out_valid_next;
    end
  end

  assign in_ready  = (r_fsm == ST_IDLE);
  assign round     = r_round;
  assign out_valid = r_out_valid;
  assign out_block = r_out_block;

endmodule

// File: tb/tb_aes_decipher_iter.sv
// Directed bench for aes_decipher_iter using FIPS-197 vectors; round keys expanded locally.
module tb_aes_decipher_iter;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] K_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, abort, in_valid, in_keylen, out_ready;
  logic         in_ready, out_valid;
  logic [127:0] in_block, round_key, out_block;
  logic [3:0]   round;

  logic         b_in_valid, b_in_keylen, b_out_ready, b_in_ready, b_out_valid;
  logic [127:0] b_in_block, b_round_key, b_out_block;
  logic [3:0]   b_round;

  logic [127:0] rk [3][15];
  int key_sel;
  int total = 0;
  int bad = 0;

  always_comb round_key   = rk[key_sel][round];
  always_comb b_round_key = rk[0][b_round];

  aes_decipher_iter #(.KEY256_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .in_keylen(in_keylen), .in_block(in_block), .round(round), .round_key(round_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block)
  );

  aes_decipher_iter #(.KEY256_EN(0)) dut128 (
    .clk(clk), .reset_n(reset_n), .abort(1'b0), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_keylen(b_in_keylen), .in_block(b_in_block), .round(b_round), .round_key(b_round_key),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_block(b_out_block)
  );

  // Forward S-box built from field arithmetic, used only for key expansion.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gmul(inv, inv);
      if (i != 0) inv = gmul(inv, x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_fwd(w[31:24]), sbox_fwd(w[23:16]), sbox_fwd(w[15:8]), sbox_fwd(w[7:0])};
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk, input int sel);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic issue(input logic [127:0] blk, input logic kl);
    @(negedge clk);
    in_block  = blk;
    in_keylen = kl;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid === 1'b1) break;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_keylen = 1'b0; out_ready = 1'b1;
    in_block = '0; b_in_valid = 1'b0; b_in_keylen = 1'b0; b_out_ready = 1'b1; b_in_block = '0;
    #12;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (round !== 4'd0) begin bad++; $display("FAIL reset_round: got %0d want 0", round); end
    total++; if (out_block !== 128'h0) begin bad++; $display("FAIL reset_out_block: got %h want 0", out_block); end
    total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL reset_b_in_ready: got %b want 1", b_in_ready); end
    $display("reset: in_ready=%b out_valid=%b round=%0d", in_ready, out_valid, round);
  endtask

  task automatic test_aes128;
    int lat;
    key_sel = 0;
    issue(CT_C1, 1'b0);
    total++; if (round !== 4'd10) begin bad++; $display("FAIL aes128_first_round: got %0d want 10", round); end
    wait_out(lat);
    total++; if (lat !== 11) begin bad++; $display("FAIL aes128_latency: got %0d want 11", lat); end
    total++; if (out_block !== PT_C1) begin bad++; $display("FAIL aes128_data: got %h want %h", out_block, PT_C1); end
    $display("aes128 C.1: latency=%0d out=%h", lat, out_block);
  endtask

  task automatic test_aes256;
    int lat;
    key_sel = 2;
    issue(CT_C3, 1'b1);
    total++; if (round !== 4'd14) begin bad++; $display("FAIL aes256_first_round: got %0d want 14", round); end
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid === 1'b1) break;
      total++;
      if (round !== 4'(14 - lat)) begin bad++; $display("FAIL aes256_round_seq: got %0d want %0d", round, 14 - lat); end
    end
    total++; if (lat !== 15) begin bad++; $display("FAIL aes256_latency: got %0d want 15", lat); end
    total++; if (out_block !== PT_C1) begin bad++; $display("FAIL aes256_data: got %h want %h", out_block, PT_C1); end
    total++; if (round !== 4'd0) begin bad++; $display("FAIL aes256_idle_round: got %0d want 0", round); end
    $display("aes256 C.3: latency=%0d out=%h", lat, out_block);
  endtask

  task automatic test_backpressure;
    int lat;
    key_sel = 0;
    issue(CT_C1, 1'b0);
    wait_out(lat);
    out_ready = 1'b0;
    key_sel = 1;
    issue(CT_B, 1'b0);
    repeat (13) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_in_ready: got %b want 0", in_ready); end
    total++; if (round !== 4'd0) begin bad++; $display("FAIL bp_stall_round: got %0d want 0", round); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid: got %b want 1", out_valid); end
    total++; if (out_block !== PT_C1) begin bad++; $display("FAIL bp_hold_data: got %h want %h", out_block, PT_C1); end
    repeat (4) @(negedge clk);
    total++; if (out_block !== PT_C1) begin bad++; $display("FAIL bp_hold_data_late: got %h want %h", out_block, PT_C1); end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_release_valid: got %b want 1", out_valid); end
    total++; if (out_block !== PT_B) begin bad++; $display("FAIL bp_release_data: got %h want %h", out_block, PT_B); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_idle: got %b want 1", in_ready); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain_valid: got %b want 0", out_valid); end
    $display("backpressure: second result %h", PT_B);
  endtask

  task automatic test_back_to_back;
    logic [127:0] cts [3];
    logic [127:0] pts [3];
    int sels [3];
    int nrs [3];
    int acc [3];
    int k, j, cyc;
    cts = '{CT_C1, CT_B, CT_C3};
    pts = '{PT_C1, PT_B, PT_C1};
    sels = '{0, 1, 2};
    nrs = '{10, 10, 14};
    k = 0; j = 0; cyc = 0;
    @(negedge clk);
    while (cyc < 80 && j < 3) begin
      if (out_valid === 1'b1) begin
        total++;
        if (out_block !== pts[j]) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", j, out_block, pts[j]); end
        $display("b2b result %0d: %h", j, out_block);
        j++;
      end
      if (k == 3) in_valid = 1'b0;
      if (k < 3 && in_ready === 1'b1) begin
        key_sel = sels[k];
        in_block = cts[k];
        in_keylen = (nrs[k] == 14);
        in_valid = 1'b1;
        acc[k] = cyc;
        if (k > 0) begin
          total++;
          if (acc[k] - acc[k-1] !== nrs[k-1] + 2) begin
            bad++; $display("FAIL b2b_spacing%0d: got %0d want %0d", k, acc[k] - acc[k-1], nrs[k-1] + 2);
          end
        end
        k++;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (j !== 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", j); end
  endtask

  task automatic test_abort;
    int n, lat;
    key_sel = 0;
    issue(CT_C1, 1'b0);
    n = 0;
    while (n < 20 && round !== 4'd5) begin @(negedge clk); n++; end
    total++; if (in_ready !== 1'b0 || round !== 4'd5) begin bad++; $display("FAIL abort_reach_r5: got round %0d in_ready %b want 5/0", round, in_ready); end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_idle: got %b want 1", in_ready); end
    total++; if (round !== 4'd0) begin bad++; $display("FAIL abort_round: got %0d want 0", round); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_out_valid: got %b want 0", out_valid); end
    abort = 1'b1; in_valid = 1'b1; in_block = CT_B;
    @(posedge clk);
    #1 abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || round !== 4'd0) begin bad++; $display("FAIL abort_beats_accept: got in_ready %b round %0d want 1/0", in_ready, round); end
    key_sel = 1;
    issue(CT_B, 1'b0);
    wait_out(lat);
    total++; if (lat !== 11) begin bad++; $display("FAIL abort_next_latency: got %0d want 11", lat); end
    total++; if (out_block !== PT_B) begin bad++; $display("FAIL abort_next_data: got %h want %h", out_block, PT_B); end
    $display("abort: next block out=%h", out_block);
  endtask

  task automatic test_reset_mid;
    logic seen;
    key_sel = 0;
    issue(CT_C1, 1'b0);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++; if (round !== 4'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_fsm: got round %0d in_ready %b want 0/1", round, in_ready); end
    total++; if (out_valid !== 1'b0 || out_block !== 128'h0) begin bad++; $display("FAIL rstmid_out: got valid %b block %h want 0/0", out_valid, out_block); end
    #1 reset_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_output: got %b want 0", seen); end
    $display("reset mid-block: no output seen=%b", seen);
  endtask

  task automatic test_key128_only;
    int lat;
    @(negedge clk);
    b_in_block = CT_C1; b_in_keylen = 1'b1; b_in_valid = 1'b1;
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    total++; if (b_round !== 4'd10) begin bad++; $display("FAIL k128_first_round: got %0d want 10", b_round); end
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (b_out_valid === 1'b1) break;
    end
    total++; if (lat !== 11) begin bad++; $display("FAIL k128_latency: got %0d want 11", lat); end
    total++; if (b_out_block !== PT_C1) begin bad++; $display("FAIL k128_data: got %h want %h", b_out_block, PT_C1); end
    $display("aes128-only build: latency=%0d out=%h", lat, b_out_block);
  endtask

  initial begin
    key_sel = 0;
    expand_key({K_C1, 128'h0}, 4, 0);
    expand_key({K_B, 128'h0}, 4, 1);
    expand_key(K_C3, 8, 2);
    test_reset();
    test_aes128();
    test_aes256();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_key128_only();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
